// File: rtl/i2c_slave_serial_engine.sv
// I2C slave protocol engine: conditions SCL/SDA, matches the device address and
// turns bus writes/reads into register-file addr/dataIn/writeEn/dataOut traffic.
module i2c_slave_serial_engine #(
    parameter logic [6:0]  DEVICE_ADDRESS = 7'h3C,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out_en,
    output logic [7:0] reg_addr,
    output logic [7:0] data_to_regif,
    output logic       write_en,
    input  logic [7:0] data_from_regif
);

    // state     | meaning
    // IDLE      | bus free, waiting for START
    // DEV_ADDR  | shifting in device address + R/W
    // DEV_ACK   | ACKing device address
    // REG_ADDR  | shifting in register pointer
    // REG_ACK   | ACKing register pointer
    // WR_DATA   | shifting in write data
    // WR_ACK    | ACKing write data (write strobe issued here)
    // RD_DATA   | shifting out read data
    // RD_ACK    | sampling master ACK/NACK
    // WAIT_STOP | not addressed / read ended, ignore until START/STOP
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_e;

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    // Index 0 carries SCL, index 1 carries SDA.
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
    logic [1:0][3:0] filt_cnt_q, filt_cnt_d;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = filt_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                filt_cnt_d[i] = '0;
            end else if (filt_cnt_q[i] == FILT_MAX) begin
                filt_d[i]     = sync2_q[i];
                filt_cnt_d[i] = '0;
            end else begin
                filt_cnt_d[i] = filt_cnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            filt_prev_q <= 2'b11;
            filt_cnt_q  <= '0;
        end else begin
            sync1_q     <= {sda_in, scl_in};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    logic scl_rise, scl_fall, sda_bit, start_det, stop_det;

    assign scl_rise  =  filt_q[0] & ~filt_prev_q[0];
    assign scl_fall  = ~filt_q[0] &  filt_prev_q[0];
    assign sda_bit   =  filt_q[1];
    assign start_det = ~filt_q[1] & filt_prev_q[1] & filt_q[0] & filt_prev_q[0];
    assign stop_det  =  filt_q[1] & ~filt_prev_q[1] & filt_q[0] & filt_prev_q[0];

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  data_q, data_d;
    logic        wen_q, wen_d;
    logic [7:0]  rx_byte;

    assign rx_byte = {shift_q[6:0], sda_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            reg_addr_q <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            reg_addr_q <= reg_addr_d;
            data_q     <= data_d;
            wen_q      <= wen_d;
        end
    end

    // ACK states see two SCL falls; sda_oe_q tells the opening fall from the closing one.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = DEV_ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                DEV_ADDR: if (scl_rise && bit_cnt_q == 3'd7)
                    state_d = (shift_q[6:0] == DEVICE_ADDRESS) ? DEV_ACK : WAIT_STOP;
                DEV_ACK:  if (scl_fall && sda_oe_q)
                    state_d = shift_q[0] ? RD_DATA : REG_ADDR;
                REG_ADDR: if (scl_rise && bit_cnt_q == 3'd7) state_d = REG_ACK;
                REG_ACK:  if (scl_fall && sda_oe_q) state_d = WR_DATA;
                WR_DATA:  if (scl_rise && bit_cnt_q == 3'd7) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && sda_oe_q) state_d = WR_DATA;
                RD_DATA:  if (scl_fall && bit_cnt_q == 3'd0) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_bit) state_d = WAIT_STOP;
                    else if (scl_fall)       state_d = RD_DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        data_d     = data_q;
        wen_d      = 1'b0;
        reg_addr_d = wen_q ? reg_addr_q + 8'd1 : reg_addr_q;
        if (start_det || stop_det) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (state_q == REG_ADDR && bit_cnt_q == 3'd7) reg_addr_d = rx_byte;
                    end
                end
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == WR_ACK) begin
                                data_d = shift_q;
                                wen_d  = 1'b1;
                            end
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == DEV_ACK && shift_q[0]) begin
                                shift_d  = data_from_regif;
                                sda_oe_d = ~data_from_regif[7];
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_bit) reg_addr_d = reg_addr_q + 8'd1;
                    end else if (scl_fall) begin
                        shift_d   = data_from_regif;
                        sda_oe_d  = ~data_from_regif[7];
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_out_en    = sda_oe_q;
    assign reg_addr      = reg_addr_q;
    assign data_to_regif = data_q;
    assign write_en      = wen_q;

endmodule

// File: tb/tb_i2c_slave_serial_engine.sv
// Directed bench for i2c_slave_serial_engine: a bit-banged I2C master plus a
// register model that answers reads with addr + 0x10.
module tb_i2c_slave_serial_engine;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_out_en;
    logic [7:0] reg_addr, data_to_regif, data_from_regif;
    logic       write_en;

    assign sda_bus = sda_m & ~sda_out_en;

    i2c_slave_serial_engine #(.DEVICE_ADDRESS(7'h3C), .FILTER_LEN(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .scl_in          (scl_m),
        .sda_in          (sda_bus),
        .sda_out_en      (sda_out_en),
        .reg_addr        (reg_addr),
        .data_to_regif   (data_to_regif),
        .write_en        (write_en),
        .data_from_regif (data_from_regif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) data_from_regif <= reg_addr + 8'h10;

    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         oe_cnt = 0, wen_long = 0, wen_misalign = 0;
    logic       wen_prev = 1'b0, oe_prev = 1'b0;

    always @(negedge clk) begin
        if (write_en) begin
            wr_addr.push_back(reg_addr);
            wr_data.push_back(data_to_regif);
            if (wen_prev) wen_long++;
            if (!sda_out_en || oe_prev) wen_misalign++;
        end
        if (sda_out_en) oe_cnt++;
        wen_prev = write_en;
        oe_prev  = sda_out_en;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(2*Q);
        sda_m = 1'b0; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(2*Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    // One SCL period; optional 2-clk low glitch in the middle of the high phase.
    task automatic clock_bit(input logic b, input logic glitch, output logic rx);
        sda_m = b; tick(Q);
        scl_m = 1'b1;
        if (glitch) begin
            tick(3); scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(Q-5);
        end else begin
            tick(Q);
        end
        rx = sda_bus; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == gbit), rx);
        clock_bit(1'b1, 1'b0, rx);
        ack = ~rx;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic rx;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, rx);
            d = {d[6:0], rx};
        end
        clock_bit(mack, 1'b0, rx);
    endtask

    typedef struct {
        logic [7:0] ptr, d0, d1, exp_a0, exp_a1, exp_ptr;
    } wr_vec_t;

    wr_vec_t    vecs[3];
    logic       a0, a1, a2, a3;
    logic [7:0] rd0, rd1;
    int         base, oe_base;

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ptr: 8'h02, d0: 8'hA5, d1: 8'h5A, exp_a0: 8'h02, exp_a1: 8'h03, exp_ptr: 8'h04};
        vecs[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22, exp_a0: 8'hFF, exp_a1: 8'h00, exp_ptr: 8'h01};
        vecs[2] = '{ptr: 8'h7F, d0: 8'h3C, d1: 8'hC3, exp_a0: 8'h7F, exp_a1: 8'h80, exp_ptr: 8'h81};

        tick(5);
        rst = 1'b0;
        tick(2);
        check("reset_sda_out_en", 32'(sda_out_en), 0);
        check("reset_reg_addr", 32'(reg_addr), 0);
        check("reset_data", 32'(data_to_regif), 0);
        check("reset_write_en", 32'(write_en), 0);

        for (int v = 0; v < 3; v++) begin
            base = wr_addr.size();
            bus_start();
            send_byte(8'h78, -1, a0);
            send_byte(vecs[v].ptr, -1, a1);
            send_byte(vecs[v].d0, -1, a2);
            send_byte(vecs[v].d1, -1, a3);
            bus_stop();
            tick(4);
            check($sformatf("wr%0d_acks", v), 32'({a0, a1, a2, a3}), 32'hF);
            check($sformatf("wr%0d_count", v), 32'(wr_addr.size() - base), 2);
            if (wr_addr.size() >= base + 2) begin
                check($sformatf("wr%0d_addr0", v), 32'(wr_addr[base]), 32'(vecs[v].exp_a0));
                check($sformatf("wr%0d_data0", v), 32'(wr_data[base]), 32'(vecs[v].d0));
                check($sformatf("wr%0d_addr1", v), 32'(wr_addr[base+1]), 32'(vecs[v].exp_a1));
                check($sformatf("wr%0d_data1", v), 32'(wr_data[base+1]), 32'(vecs[v].d1));
            end
            check($sformatf("wr%0d_ptr", v), 32'(reg_addr), 32'(vecs[v].exp_ptr));
        end

        // Random read with repeated START, master ACK then NACK.
        base = wr_addr.size();
        bus_start();
        send_byte(8'h78, -1, a0);
        send_byte(8'h02, -1, a1);
        bus_start();
        send_byte(8'h79, -1, a2);
        recv_byte(1'b0, rd0);
        recv_byte(1'b1, rd1);
        bus_stop();
        tick(4);
        check("rd_acks", 32'({a0, a1, a2}), 32'h7);
        check("rd_byte0", 32'(rd0), 32'h12);
        check("rd_byte1", 32'(rd1), 32'h13);
        check("rd_ptr", 32'(reg_addr), 32'h03);
        check("rd_no_write", 32'(wr_addr.size() - base), 0);

        // Address mismatch: slave must stay off the line.
        oe_base = oe_cnt;
        bus_start();
        send_byte(8'h7A, -1, a0);
        send_byte(8'h55, -1, a1);
        bus_stop();
        tick(4);
        check("mm_acks", 32'({a0, a1}), 0);
        check("mm_oe_cycles", 32'(oe_cnt - oe_base), 0);
        check("mm_no_write", 32'(wr_addr.size() - base), 0);
        bus_start();
        send_byte(8'h78, -1, a0);
        bus_stop();
        check("mm_next_ack", 32'(a0), 1);

        // Abort: STOP after 4 data bits.
        base = wr_addr.size();
        bus_start();
        send_byte(8'h78, -1, a0);
        send_byte(8'h40, -1, a1);
        clock_bit(1'b1, 1'b0, a2);
        clock_bit(1'b0, 1'b0, a2);
        clock_bit(1'b1, 1'b0, a2);
        clock_bit(1'b1, 1'b0, a2);
        bus_stop();
        tick(4);
        check("abort_no_write", 32'(wr_addr.size() - base), 0);
        check("abort_ptr", 32'(reg_addr), 32'h40);
        check("abort_state_idle", 32'(dut.state_q), 0);
        check("abort_oe", 32'(sda_out_en), 0);

        // SCL glitch mid-byte is filtered out.
        base = wr_addr.size();
        bus_start();
        send_byte(8'h78, -1, a0);
        send_byte(8'h30, -1, a1);
        send_byte(8'hC3, 3, a2);
        bus_stop();
        tick(4);
        check("gl_acks", 32'({a0, a1, a2}), 32'h7);
        check("gl_count", 32'(wr_addr.size() - base), 1);
        if (wr_addr.size() > base) begin
            check("gl_addr", 32'(wr_addr[base]), 32'h30);
            check("gl_data", 32'(wr_data[base]), 32'hC3);
        end

        check("wen_single_cycle", 32'(wen_long), 0);
        check("wen_with_ack_rise", 32'(wen_misalign), 0);

        // Reset while the slave drives the register-pointer ACK.
        bus_start();
        send_byte(8'h78, -1, a0);
        for (int i = 7; i >= 0; i--) clock_bit(i == 0 || i == 2, 1'b0, a1);
        check("rst_ack_driven", 32'(sda_out_en), 1);
        rst = 1'b1;
        #1;
        check("rst_oe_async", 32'(sda_out_en), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_data", 32'(data_to_regif), 0);
        check("rst_write_en", 32'(write_en), 0);
        tick(3);
        rst = 1'b0;
        bus_stop();
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_serial_engine.md
# i2c_slave_serial_engine

I2C slave protocol engine that sits directly upstream of the register-file stage. It samples the bus SCL/SDA lines, detects START/STOP, matches the 7-bit device address, and tracks a register pointer. It converts bus write/read transactions into the `addr` / `dataIn` / `writeEn` / `dataOut` port set consumed by the register interface. SDA is open-drain: the block only asserts a pull-low enable; the pad tristate lives at top level.

## Interface
- `DEVICE_ADDRESS`, 7'h3C: 7-bit slave address matched against the first byte after START.
- `FILTER_LEN`, 4: consecutive identical synchronized samples required before a filtered SCL/SDA level changes (range 1–15).
- `clk` in 1: system clock; must run at ≥ 20× the SCL frequency.
- `rst` in 1: **asynchronous, active-high** reset.
- `scl_in` in 1: raw bus SCL, asynchronous to `clk`.
- `sda_in` in 1: raw bus SDA, asynchronous to `clk`.
- `sda_out_en` out 1: 1 = drive SDA low; 0 = release the line.
- `reg_addr` out 8: register pointer; connects to the register stage `addr`.
- `data_to_regif` out 8: received write byte; connects to `dataIn`.
- `write_en` out 1: single-clk write strobe; connects to `writeEn`.
- `data_from_regif` in 8: read data; connects to `dataOut`, which is registered 1 clk after `reg_addr`.

## Operation
- **Input conditioning**
  - Each line passes through a 2-flop synchronizer, then a FILTER_LEN-deep deglitch counter.
  - Events are derived from the filtered levels only:
    - SCL rise and SCL fall.
    - START: SDA falls while SCL = 1.
    - STOP: SDA rises while SCL = 1.
- **Bit handling**
  - Incoming bits are sampled MSB-first on SCL rise.
  - SDA output changes only on SCL fall.
  - A 3-bit counter tracks bits; the 9th clock is ACK.
- **States**: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- **Transitions**
  - START in any state (including a repeated START) → DEV_ADDR, bit counter cleared, `sda_out_en` = 0.
  - STOP in any state → IDLE, `sda_out_en` = 0.
  - DEV_ADDR, after 8 bits:
    - address ≠ DEVICE_ADDRESS → WAIT_STOP, no ACK (SDA stays released).
    - address matches → DEV_ACK. `sda_out_en` = 1 from the SCL fall after bit 8 until the next SCL fall.
  - DEV_ACK, R/W = 0 → REG_ADDR.
  - DEV_ACK, R/W = 1 → RD_DATA. At the ACK-ending SCL fall, the shift register loads `data_from_regif` and SDA drives the MSB.
  - REG_ADDR, 8 bits received → `reg_addr` loads the byte → REG_ACK (ACK driven) → WR_DATA.
  - WR_DATA, 8 bits received → `data_to_regif` loads the byte, `write_en` pulses, ACK driven → WR_ACK → WR_DATA. The master may stream further bytes.
  - RD_DATA, 8 bits shifted out → SDA released → RD_ACK, where the master's bit is sampled on SCL rise:
    - 0 (ACK): `reg_addr` increments → RD_DATA, reloaded at the next SCL fall.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: ignores everything except START/STOP.
- **Arithmetic**: `reg_addr` increments modulo 256 (8'hFF → 8'h00), 1 clk after each `write_en` and on each master ACK. The pointer is retained across transactions.
- **Reset values**: `sda_out_en` = 0, `reg_addr` = 8'h00, `data_to_regif` = 8'h00, `write_en` = 0, state IDLE, bit counter 0.
- **Reset mid-transfer**: the line is released immediately (asynchronous) and no partial write is committed.

## Timing
- Input latency: 2 sync flops + FILTER_LEN clk from pin edge to event (6 clk at default).
- ACK drive: `sda_out_en` rises 1 clk after the filtered SCL fall following bit 8.
- `write_en`: high for exactly 1 clk, in the same clk that `sda_out_en` rises for WR_ACK. `data_to_regif` is valid in that clk and holds until the next write.
- Pointer update: `reg_addr` changes 1 clk after the `write_en` pulse.
- Read load: the shift register samples `data_from_regif` ≥ 2 clk after the last `reg_addr` change; guaranteed by the ≥ 10-clk SCL half-period.
- START/STOP versus SCL: when a START or STOP coincides with an SCL edge in the same clk, START/STOP takes priority.

## Test plan
- **Write**: START, 0x78 (0x3C+W), reg 0x02, data 0xA5, 0x5A, STOP.
  - `write_en` pulses twice: (addr 02, A5) then (03, 5A).
  - Slave ACKs all 4 bytes.
  - `reg_addr` = 0x04 after STOP.
- **Random read**: START, 0x78, reg 0x02, repeated START, 0x79, master ACK then NACK, STOP (register model returns addr+0x10).
  - SDA carries 0x12, then 0x13.
  - `reg_addr` ends at 0x03.
- **Address mismatch**: START, 0x7A, data 0x55, STOP.
  - `sda_out_en` stays 0 throughout; no `write_en`.
  - Next START with 0x78 is ACKed.
- **Wrap**: write reg 0xFF, data 0x11, 0x22.
  - Writes land at addr 0xFF then 0x00.
  - `reg_addr` = 0x01.
- **Abort**: STOP after 4 data bits of a write → no `write_en`; state IDLE.
  - `rst` pulsed while the slave drives ACK → `sda_out_en` = 0 in the same cycle; all outputs at reset values.
- **Glitch**: a 2-clk low pulse on SCL mid-byte (FILTER_LEN = 4) → ignored; the received byte is unchanged.
